// File: rtl/pulse_stretch.sv
// Pulse stretcher: replays single-cycle event strobes as fixed-width output
// pulses with a guaranteed low gap, queuing events that arrive mid-pulse.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no pulse in flight, queue empty; next event starts directly
//   S_HIGH | dout high, counting down HIGH_CYCLES
//   S_LOW  | dout low gap, counting down LOW_CYCLES; last cycle may restart
module pulse_stretch #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic              dout,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0]     HI_LOAD  = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0]     LO_LOAD  = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          start;

  // A new pulse begins on the final gap cycle if anything is queued or arriving.
  assign start = (state == S_LOW) && (cnt == '0) && ((pending != '0) || din);

  // Sequencer, down-counter, event queue and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dout     <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;

      case (state)
        S_IDLE: begin
          if (din) begin
            state <= S_HIGH;
            cnt   <= HI_LOAD;
            dout  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_HIGH: begin
          if (cnt == '0) begin
            state <= S_LOW;
            cnt   <= LO_LOAD;
            dout  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_LOW: begin
          if (cnt == '0) begin
            if (start) begin
              state <= S_HIGH;
              cnt   <= HI_LOAD;
              dout  <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          dout  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

      // In IDLE an event is consumed directly, so the queue only moves while busy.
      // A start with an empty queue is the arriving event itself: nothing to pop.
      if (state != S_IDLE) begin
        if (start) begin
          if (pending != '0 && !din) begin
            pending <= pending - PEND_ONE;
          end
        end else if (din) begin
          if (pending != PEND_MAX) begin
            pending <= pending + PEND_ONE;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: default instance (PEND_W=4) plus a
// PEND_W=2 instance for saturation. "Cycle k" values are sampled on the
// falling edge just before posedge k; din for posedge k is driven there too.
module tb_pulse_stretch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din_a = 1'b0;
  logic       din_b = 1'b0;
  logic       dout_a, busy_a, ovf_a;
  logic       dout_b, busy_b, ovf_b;
  logic [3:0] pend_a;
  logic [1:0] pend_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;

  pulse_stretch #(.HIGH_CYCLES(4), .LOW_CYCLES(4), .PEND_W(4)) dut_a (
    .clk(clk), .rst(rst), .din(din_a),
    .dout(dout_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
  );

  pulse_stretch #(.HIGH_CYCLES(4), .LOW_CYCLES(4), .PEND_W(2)) dut_b (
    .clk(clk), .rst(rst), .din(din_b),
    .dout(dout_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic logic [63:0] w(input int lo, input int hi);
    logic [63:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic to_cycle(input int k);
    while ((cyc - base) < k) @(negedge clk);
  endtask

  task automatic start_test();
    @(negedge clk);
    din_a = 1'b0;
    din_b = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    base = cyc;
  endtask

  task automatic run(input string name, input bit sel,
                     input logic [63:0] din_v, input logic [63:0] dout_v,
                     input logic [63:0] busy_v, input logic [63:0] ovf_v,
                     input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      to_cycle(k);
      chk($sformatf("%s dout c%0d", name, k), sel ? dout_b : dout_a, dout_v[k]);
      chk($sformatf("%s busy c%0d", name, k), sel ? busy_b : busy_a, busy_v[k]);
      chk($sformatf("%s ovf c%0d",  name, k), sel ? ovf_b  : ovf_a,  ovf_v[k]);
      if (sel) din_b = din_v[k];
      else     din_a = din_v[k];
    end
  endtask

  initial begin
    logic [63:0] dv, ov, bv, iv;

    // reset state
    #2;
    chk("rst dout", dout_a, 0);
    chk("rst busy", busy_a, 0);
    chk("rst pend", pend_a, 0);
    chk("rst ovf",  ovf_a,  0);
    chk("rst pend_b", pend_b, 0);

    // 1: single event
    start_test();
    iv = w(10, 10);
    run("t1", 0, iv, w(11, 14), w(11, 18), '0, 1, 14);
    chk("t1 pend c14", pend_a, 0);
    run("t1", 0, iv, w(11, 14), w(11, 18), '0, 15, 25);
    chk("t1 pend end", pend_a, 0);

    // 2: queued events
    start_test();
    iv = w(10, 10) | w(12, 13);
    dv = w(11, 14) | w(19, 22) | w(27, 30);
    bv = w(11, 34);
    run("t2", 0, iv, dv, bv, '0, 1, 14);
    chk("t2 pend c14", pend_a, 2);
    run("t2", 0, iv, dv, bv, '0, 15, 20);
    chk("t2 pend c20", pend_a, 1);
    run("t2", 0, iv, dv, bv, '0, 21, 40);
    chk("t2 pend end", pend_a, 0);

    // 3: overflow with a 2-bit queue
    start_test();
    iv = w(10, 10) | w(12, 16);
    dv = w(11, 14) | w(19, 22) | w(27, 30) | w(35, 38);
    bv = w(11, 42);
    ov = w(16, 17);
    run("t3", 1, iv, dv, bv, ov, 1, 15);
    chk("t3 pend c15", pend_b, 3);
    run("t3", 1, iv, dv, bv, ov, 16, 17);
    chk("t3 pend c17", pend_b, 3);
    run("t3", 1, iv, dv, bv, ov, 18, 50);
    chk("t3 pend end", pend_b, 0);

    // 4a: event on the last gap cycle with one queued
    start_test();
    iv = w(10, 10) | w(12, 12) | w(18, 18);
    dv = w(11, 14) | w(19, 22) | w(27, 30);
    bv = w(11, 34);
    run("t4a", 0, iv, dv, bv, '0, 1, 20);
    chk("t4a pend c20", pend_a, 1);
    run("t4a", 0, iv, dv, bv, '0, 21, 40);
    chk("t4a pend end", pend_a, 0);

    // 4b: event on the last gap cycle with nothing queued
    start_test();
    iv = w(10, 10) | w(18, 18);
    dv = w(11, 14) | w(19, 22);
    bv = w(11, 26);
    run("t4b", 0, iv, dv, bv, '0, 1, 20);
    chk("t4b pend c20", pend_a, 0);
    run("t4b", 0, iv, dv, bv, '0, 21, 30);

    // 5: asynchronous reset in the middle of a queued replay
    start_test();
    iv = w(10, 10) | w(12, 13);
    run("t5", 0, iv, w(11, 14), w(11, 34), '0, 1, 14);
    chk("t5 pend pre", pend_a, 2);
    #1 rst = 1'b0;
    #1;
    chk("t5 dout async", dout_a, 0);
    chk("t5 busy async", busy_a, 0);
    chk("t5 pend async", pend_a, 0);
    chk("t5 ovf async",  ovf_a,  0);
    din_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk($sformatf("t5 dout quiet %0d", k), dout_a, 0);
      chk($sformatf("t5 busy quiet %0d", k), busy_a, 0);
    end

    // 6: din held as a level for three cycles
    start_test();
    iv = w(10, 12);
    dv = w(11, 14) | w(19, 22) | w(27, 30);
    bv = w(11, 34);
    run("t6", 0, iv, dv, bv, '0, 1, 14);
    chk("t6 pend c14", pend_a, 2);
    run("t6", 0, iv, dv, bv, '0, 15, 40);
    chk("t6 pend end", pend_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
